// File: rtl/dse3w_pkg.sv
// Shared types and helpers for the 3-wire data-strobe transmitter and its encoder.
package dse3w_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef logic [1:0] wire_idx_t;

  localparam wire_idx_t L_RESET = 2'd2;

  // Wire to toggle for bit b when wire l toggled last: (l + 1 + b) mod 3.
  function automatic wire_idx_t next_wire(input wire_idx_t l, input logic b);
    logic [2:0] sum;
    sum = {1'b0, l} + 3'd1 + {2'b00, b};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/dse3w_symbol_enc.sv
// DS symbol encoder: owns the three line flops and the last-toggled wire index.
// One strobe toggles exactly one wire, chosen from the previous wire and the bit value.
module dse3w_symbol_enc
  import dse3w_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe_i,
  input  logic       bit_i,
  input  logic       clear_i,
  output logic [2:0] line_o
);

  logic [2:0] line_q;
  wire_idx_t  l_q;
  wire_idx_t  w_nxt;
  logic [2:0] toggle_mask;

  assign w_nxt       = next_wire(l_q, bit_i);
  assign toggle_mask = 3'b001 << w_nxt;

  // NOTE: reset is synchronous; rst_n is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      line_q <= 3'b000;
      l_q    <= L_RESET;
    end else if (strobe_i) begin
      line_q <= line_q ^ toggle_mask;
      l_q    <= w_nxt;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/dse3w_tx_sched.sv
// Transmit scheduler: round-robin arbitration per frame between two byte sources,
// divider-paced LSB-first serialization into the DS symbol encoder.
module dse3w_tx_sched
  import dse3w_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int GAP_SYMS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_last,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic [1:0]       req_ready,
  output logic [2:0]       line_out,
  output logic             busy,
  output logic             grant_id
);

  localparam int GAP_W = (GAP_SYMS > 1) ? $clog2(GAP_SYMS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_SYMS - 1);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             strobe;
  logic             cnt_zero;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;

  assign cnt_zero  = (cnt_q == '0);
  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = grant_q ? req_data1 : req_data0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      shift_q  <= 8'h00;
      last_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      bitcnt_q <= 3'd0;
      gap_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      gap_q    <= gap_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    shift_d  = shift_q;
    last_d   = last_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    gap_d    = gap_q;
    strobe   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en && (req_valid != 2'b00)) begin
          state_d = ST_FETCH;
          // Contention goes to the pointer; a lone requester always wins.
          grant_d = (req_valid == 2'b11) ? rr_q : req_valid[1];
        end
      end

      ST_FETCH: begin
        // Underrun simply parks here with the grant held and the line static.
        if (sel_valid) begin
          shift_d  = sel_data;
          last_d   = sel_last;
          div_d    = div;
          cnt_d    = div;
          bitcnt_d = 3'd0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_zero) begin
          strobe   = 1'b1;
          shift_d  = shift_q >> 1;
          cnt_d    = div_q;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (last_q) begin
              state_d = ST_GAP;
              gap_d   = '0;
              rr_d    = ~grant_q;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          cnt_d = div_q;
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  dse3w_symbol_enc u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (strobe),
    .bit_i    (shift_q[0]),
    .clear_i  (1'b0),
    .line_o   (line_out)
  );

  assign req_ready = (state_q == ST_FETCH) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_dse3w_tx_sched.sv
// Directed bench for dse3w_tx_sched: symbol sequences, divider pacing, arbitration,
// underrun hold and mid-frame reset, all against hand-computed expectations.
module tb_dse3w_tx_sched;

  localparam int DIV_W    = 8;
  localparam int GAP_SYMS = 2;

  // Line states after bits 0..7, bit i in [3*i +: 3], starting from L=2.
  localparam logic [23:0] SEQ_00 = {3'b011, 3'b001, 3'b000, 3'b100,
                                    3'b110, 3'b111, 3'b011, 3'b001};
  localparam logic [23:0] SEQ_FF = {3'b011, 3'b010, 3'b000, 3'b100,
                                    3'b101, 3'b111, 3'b011, 3'b010};

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [1:0]       req_valid;
  logic [1:0]       req_last;
  logic [7:0]       req_data0;
  logic [7:0]       req_data1;
  logic [1:0]       req_ready;
  logic [2:0]       line_out;
  logic             busy;
  logic             grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  dse3w_tx_sched #(
    .DIV_W    (DIV_W),
    .GAP_SYMS (GAP_SYMS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div       (div),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .line_out  (line_out),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    req_last  = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  // One byte with last=1 from requester 0; checks every cycle through the gap.
  task automatic single_byte(input string tag, input logic [7:0] data,
                             input logic [DIV_W-1:0] d, input logic [23:0] seq);
    int dd;
    int m;
    logic [2:0] exp_line;
    dd        = int'(d) + 1;
    div       = d;
    req_data0 = data;
    req_last  = 2'b01;
    req_valid = 2'b01;
    en        = 1'b1;
    @(negedge clk);
    check({tag, "_fetch_ready"}, req_ready, 2'b01);
    check({tag, "_fetch_busy"}, busy, 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    req_last  = 2'b00;
    div       = ~d;  // divider must have been latched at accept
    check({tag, "_accept_line"}, line_out, 3'b000);
    for (int k = 1; k <= 8 * dd; k++) begin
      @(negedge clk);
      m = k / dd;
      exp_line = (m == 0) ? 3'b000 : seq[3*(m-1) +: 3];
      check($sformatf("%s_line_k%0d", tag, k), line_out, exp_line);
    end
    for (int j = 1; j <= GAP_SYMS * dd; j++) begin
      @(negedge clk);
      check($sformatf("%s_gap_busy_j%0d", tag, j), busy, (j < GAP_SYMS * dd) ? 1'b1 : 1'b0);
      check($sformatf("%s_gap_line_j%0d", tag, j), line_out, seq[21 +: 3]);
    end
    check({tag, "_idle_ready"}, req_ready, 2'b00);
  endtask

  initial begin
    int order[$];
    int nb[2];
    int ready_both;
    int grant_bad;
    int cur_gid;
    bit in_frame;
    logic [1:0] acc;

    rst_n     = 1'b0;
    en        = 1'b0;
    div       = '0;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    @(negedge clk);
    check("rst_line", line_out, 3'b000);
    check("rst_ready", req_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    rst_n = 1'b1;

    single_byte("b00", 8'h00, 8'd0, SEQ_00);
    do_reset();
    single_byte("bff", 8'hFF, 8'd0, SEQ_FF);
    do_reset();
    single_byte("div3", 8'hFF, 8'd3, SEQ_FF);

    // Arbitration: en=0 blocks grants, then two always-valid sources with 2-byte frames.
    do_reset();
    div        = 8'd0;
    en         = 1'b0;
    req_data0  = 8'h5A;
    req_data1  = 8'hC3;
    req_valid  = 2'b11;
    req_last   = 2'b00;
    repeat (3) @(negedge clk);
    check("en0_busy", busy, 1'b0);
    check("en0_ready", req_ready, 2'b00);
    en         = 1'b1;
    nb[0]      = 0;
    nb[1]      = 0;
    ready_both = 0;
    grant_bad  = 0;
    cur_gid    = 0;
    in_frame   = 1'b0;
    for (int cyc = 0; cyc < 400 && order.size() < 3; cyc++) begin
      if (req_ready == 2'b11) ready_both++;
      if (in_frame && (int'(grant_id) != cur_gid)) grant_bad++;
      acc = req_ready & req_valid;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (int'(grant_id) != i) grant_bad++;
          if (!in_frame) begin
            in_frame = 1'b1;
            cur_gid  = i;
          end
          if (req_last[i]) begin
            order.push_back(i);
            in_frame = 1'b0;
          end
          nb[i]++;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_last[i] = nb[i][0];
      end
    end
    req_valid = 2'b00;
    check("arb_frames", order.size(), 3);
    check("arb_first", (order.size() > 0) ? order[0] : -1, 0);
    check("arb_second", (order.size() > 1) ? order[1] : -1, 1);
    check("arb_third", (order.size() > 2) ? order[2] : -1, 0);
    check("arb_ready_11", ready_both, 0);
    check("arb_grant_stable", grant_bad, 0);

    // Underrun: req0 stalls between bytes while req1 keeps requesting.
    do_reset();
    div       = 8'd0;
    en        = 1'b1;
    req_data0 = 8'h00;
    req_data1 = 8'h55;
    req_last  = 2'b00;
    req_valid = 2'b11;
    @(negedge clk);
    check("urun_first_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("urun_line_%0d", k), line_out, 3'b011);
      check($sformatf("urun_grant_%0d", k), grant_id, 1'b0);
      check($sformatf("urun_ready_%0d", k), req_ready, 2'b01);
    end
    req_last  = 2'b01;
    req_valid = 2'b11;
    @(negedge clk);
    req_valid = 2'b10;
    req_last  = 2'b00;
    check("urun_resume_ready", req_ready, 2'b00);
    check("urun_resume_line", line_out, 3'b011);
    @(negedge clk);
    check("urun_resume_bit0", line_out, 3'b111);
    check("urun_resume_grant", grant_id, 1'b0);

    // Reset during bit 4 of a div=3 byte, then replay the 0x00 sequence.
    req_valid = 2'b00;
    do_reset();
    div       = 8'd3;
    req_data0 = 8'h3C;
    req_last  = 2'b01;
    req_valid = 2'b01;
    en        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    req_last  = 2'b00;
    repeat (17) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_line", line_out, 3'b000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 2'b00);
    check("mid_rst_grant", grant_id, 1'b0);
    rst_n = 1'b1;
    single_byte("replay", 8'h00, 8'd0, SEQ_00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
